ow_slave_tx: RTL

OW_SLAVE_TX -- requirements
Module: ow_slave_tx

---
 rtl/ow_pkg.sv | 23 ++
 rtl/ow_crc8.sv | 27 ++
 rtl/ow_slave_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ow_pkg.sv
// Shared types and constants for the 1-Wire slave transmitter.
package ow_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    HOLD      = 2'd2,
    RECOVER   = 2'd3
  } ow_state_t;

  localparam int CLK_PER_US_DEF = 1;
  localparam int T_RDV_US_DEF   = 15;
  localparam int T_RSTL_US_DEF  = 480;

  // Dallas/Maxim CRC-8 x^8+x^5+x^4+1; the reflected form suits LSB-first shifting
  localparam logic [7:0] CRC8_POLY      = 8'h31;
  localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ow_crc8.sv
// Serial Dallas CRC-8, LSB-first. Feeding din = crc[0] shifts the result out LSB first.
module ow_crc8
  import ow_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[0] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= (crc >> 1) ^ (fb ? CRC8_POLY_REFL : 8'h00);
    end
  end

endmodule

// File: rtl/ow_slave_tx.sv
// 1-Wire slave transmitter: answers master read slots with payload bits, LSB first.
// Define OW_TX_CRC8_EN to append the Dallas CRC-8 of the payload as 8 extra slots.
module ow_slave_tx
  import ow_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int T_RDV_US   = T_RDV_US_DEF,
  parameter int T_RSTL_US  = T_RSTL_US_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [DATA_W-1:0]           data,
  input  logic [$clog2(DATA_W+1)-1:0] len,
  input  logic                        bus_in,
  output logic                        bus_pull_low,
  output logic                        busy,
  output logic                        done,
  output logic                        abort
);

  localparam int LEN_W    = $clog2(DATA_W + 1);
  localparam int HOLD_CYC = T_RDV_US * CLK_PER_US;
  localparam int RSTL_CYC = T_RSTL_US * CLK_PER_US;
  localparam int CNT_W    = $clog2(max_int(HOLD_CYC, RSTL_CYC) + 1);
`ifdef OW_TX_CRC8_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int BIT_W    = $clog2(DATA_W + CRC_BITS + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic              sync_p0, sync_p1, sync_p2;
  logic              bus_low, fall;
  ow_state_t         state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bits_left, bits_nxt;
  logic [CNT_W-1:0]  hold_cnt, low_cnt;
  logic [LEN_W-1:0]  len_eff;
  logic              pull_q, pull_nxt;
  logic              done_q, done_nxt;
  logic              abort_q, abort_nxt;
  logic              accept, shift_en, rst_hit, cur_bit;

  // Stage p0/p1: metastability guard; p2 holds the previous synced level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      sync_p2 <= 1'b1;
    end else begin
      sync_p0 <= bus_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign bus_low = ~sync_p1;
  assign fall    = sync_p2 & ~sync_p1;
  assign len_eff = (len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : len;

`ifdef OW_TX_CRC8_EN
  logic [7:0] crc_q;

  ow_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .en    (shift_en),
    .din   (cur_bit),
    .crc   (crc_q)
  );

  assign cur_bit = (bits_left <= BIT_W'(CRC_BITS)) ? crc_q[0] : shreg[0];
`else
  assign cur_bit = shreg[0];
`endif

  // A bus-reset length low wins over everything, including a done in the same cycle
  assign rst_hit = (state != IDLE) && bus_low && (low_cnt == CNT_W'(RSTL_CYC - 1));

  always_comb begin
    state_nxt = state;
    bits_nxt  = bits_left;
    pull_nxt  = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    accept    = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          bits_nxt = BIT_W'(len_eff) + BIT_W'(CRC_BITS);
          if (len_eff == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = WAIT_SLOT;
          end
        end
      end
      WAIT_SLOT: begin
        if (fall) begin
          state_nxt = HOLD;
          pull_nxt  = ~cur_bit;
        end
      end
      HOLD: begin
        if (hold_cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_nxt = RECOVER;
        end else begin
          pull_nxt = pull_q;
        end
      end
      RECOVER: begin
        if (!bus_low) begin
          shift_en = 1'b1;
          bits_nxt = bits_left - BIT_W'(1);
          if (bits_left == BIT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT_SLOT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst_hit) begin
      state_nxt = IDLE;
      pull_nxt  = 1'b0;
      done_nxt  = 1'b0;
      abort_nxt = 1'b1;
      shift_en  = 1'b0;
    end
  end

  // Stage p1: control state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bits_left <= '0;
      hold_cnt  <= '0;
      low_cnt   <= '0;
      pull_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      bits_left <= bits_nxt;
      hold_cnt  <= (state == HOLD) ? sat_inc(hold_cnt) : '0;
      low_cnt   <= ((state != IDLE) && bus_low) ? sat_inc(low_cnt) : '0;
      pull_q    <= pull_nxt;
      done_q    <= done_nxt;
      abort_q   <= abort_nxt;
    end
  end

  // Payload shifter carries data only, so it has no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= data;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
  end

  assign bus_pull_low = pull_q;
  assign busy         = (state != IDLE);
  assign done         = done_q;
  assign abort        = abort_q;

endmodule
